// File: rtl/bitwise_logic_unit_if.sv
// Operand/result stream bundle for bitwise_logic_unit.
// Define BITWISE_LOGIC_FLAGS_EN to add the parity and ones result flags.
interface bitwise_logic_unit_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             acc_sel;
  logic             acc_clr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
`ifdef BITWISE_LOGIC_FLAGS_EN
  logic             parity;
  logic             ones;

  modport slave (
    input  in_valid, op, acc_sel, acc_clr, a, b, out_ready,
    output in_ready, out_valid, result, zero, parity, ones
  );
  modport master (
    output in_valid, op, acc_sel, acc_clr, a, b, out_ready,
    input  in_ready, out_valid, result, zero, parity, ones
  );
`else
  modport slave (
    input  in_valid, op, acc_sel, acc_clr, a, b, out_ready,
    output in_ready, out_valid, result, zero
  );
  modport master (
    output in_valid, op, acc_sel, acc_clr, a, b, out_ready,
    input  in_ready, out_valid, result, zero
  );
`endif
endinterface

// File: rtl/bitwise_logic_unit.sv
// Registered 8-operation bitwise logic unit with an internal accumulator and valid/ready streams.
// Define BITWISE_LOGIC_FLAGS_EN to add registered parity and all-ones flags.
module bitwise_logic_unit #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] ACC_RST = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  bitwise_logic_unit_if.slave bus
);

  localparam logic [2:0] OpAnd  = 3'b000;
  localparam logic [2:0] OpOr   = 3'b001;
  localparam logic [2:0] OpXor  = 3'b010;
  localparam logic [2:0] OpNand = 3'b011;
  localparam logic [2:0] OpNor  = 3'b100;
  localparam logic [2:0] OpXnor = 3'b101;
  localparam logic [2:0] OpAndn = 3'b110;
  localparam logic [2:0] OpNot  = 3'b111;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] res;

  // Ready while the output slot is empty or being drained this cycle.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign opnd_a   = bus.acc_sel ? acc_q : bus.a;

  always_comb begin
    res = '0;
    unique case (bus.op)
      OpAnd:   res = opnd_a & bus.b;
      OpOr:    res = opnd_a | bus.b;
      OpXor:   res = opnd_a ^ bus.b;
      OpNand:  res = ~(opnd_a & bus.b);
      OpNor:   res = ~(opnd_a | bus.b);
      OpXnor:  res = ~(opnd_a ^ bus.b);
      OpAndn:  res = opnd_a & ~bus.b;
      OpNot:   res = ~opnd_a;
      default: res = '0;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    acc_d       = acc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = res;
      zero_d      = (res == '0);
      acc_d       = res;
    end else begin
      if (bus.out_ready) out_valid_d = 1'b0;
      // A same-cycle accept takes priority over the clear.
      if (bus.acc_clr)   acc_d = ACC_RST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      acc_q       <= ACC_RST;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

`ifdef BITWISE_LOGIC_FLAGS_EN
  logic parity_q, parity_d;
  logic ones_q, ones_d;

  always_comb begin
    parity_d = parity_q;
    ones_d   = ones_q;
    if (accept) begin
      parity_d = ^res;
      ones_d   = &res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
      ones_q   <= 1'b0;
    end else begin
      parity_q <= parity_d;
      ones_q   <= ones_d;
    end
  end

  assign bus.parity = parity_q;
  assign bus.ones   = ones_q;
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed self-checking bench for bitwise_logic_unit (WIDTH=4, ACC_RST=4'hF).
// Flag checks are built in when BITWISE_LOGIC_FLAGS_EN is defined.
module tb_bitwise_logic_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bitwise_logic_unit_if #(.WIDTH(4)) bus ();

  bitwise_logic_unit #(
    .WIDTH   (4),
    .ACC_RST (4'hF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [2:0] op, input logic sel, input logic clr,
                       input logic [3:0] a, input logic [3:0] b);
    bus.in_valid = vld;
    bus.op       = op;
    bus.acc_sel  = sel;
    bus.acc_clr  = clr;
    bus.a        = a;
    bus.b        = b;
  endtask

  logic [3:0] sweep_exp [8];

  initial begin
    checks = 0;
    errors = 0;
    sweep_exp = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0100, 4'b0011};
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 4'h0, 4'h0);

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_result", {28'd0, bus.result}, 32'd0);
    check_eq("rst_zero", {31'd0, bus.zero}, 32'd1);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);

    // Op sweep, back-to-back with a=1100, b=1010
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 1'b0, 1'b0, 4'b1100, 4'b1010);
      @(negedge clk);
      check_eq($sformatf("sweep_op%0d", i), {28'd0, bus.result}, {28'd0, sweep_exp[i]});
      check_eq($sformatf("sweep_vld%0d", i), {31'd0, bus.out_valid}, 32'd1);
      check_eq($sformatf("sweep_zero%0d", i), {31'd0, bus.zero}, 32'd0);
    end
    drive(1'b0, 3'd0, 1'b0, 1'b0, 4'h0, 4'h0);
    @(negedge clk);
    check_eq("sweep_drain", {31'd0, bus.out_valid}, 32'd0);

    // Zero flag on an all-zero result
    drive(1'b1, 3'b010, 1'b0, 1'b0, 4'h6, 4'h6);
    @(negedge clk);
    check_eq("zero_result", {28'd0, bus.result}, 32'd0);
    check_eq("zero_flag", {31'd0, bus.zero}, 32'd1);

    // Mid-cycle reset with a beat in flight; acc returns to ACC_RST
    drive(1'b1, 3'b001, 1'b0, 1'b0, 4'h5, 4'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("mid_rst_result", {28'd0, bus.result}, 32'd0);
    check_eq("mid_rst_zero", {31'd0, bus.zero}, 32'd1);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 4'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Accumulate from ACC_RST=F
    drive(1'b1, 3'b000, 1'b1, 1'b0, 4'h0, 4'b1110);
    @(negedge clk);
    check_eq("acc_1", {28'd0, bus.result}, 32'b1110);
    drive(1'b1, 3'b000, 1'b1, 1'b0, 4'h0, 4'b1011);
    @(negedge clk);
    check_eq("acc_2", {28'd0, bus.result}, 32'b1010);
    drive(1'b1, 3'b000, 1'b1, 1'b0, 4'h0, 4'b0111);
    @(negedge clk);
    check_eq("acc_3", {28'd0, bus.result}, 32'b0010);
    drive(1'b0, 3'b000, 1'b1, 1'b1, 4'h0, 4'h0);
    @(negedge clk);
    check_eq("clr_hold_result", {28'd0, bus.result}, 32'b0010);
    check_eq("clr_drained", {31'd0, bus.out_valid}, 32'd0);
    drive(1'b1, 3'b000, 1'b1, 1'b0, 4'h0, 4'b1111);
    @(negedge clk);
    check_eq("acc_after_clr", {28'd0, bus.result}, 32'b1111);

    // Clear and accept together: accept wins, uses pre-clear acc
    drive(1'b1, 3'b001, 1'b0, 1'b0, 4'b0101, 4'b0000);
    @(negedge clk);
    check_eq("acc_load", {28'd0, bus.result}, 32'b0101);
    drive(1'b1, 3'b001, 1'b1, 1'b1, 4'h0, 4'b1000);
    @(negedge clk);
    check_eq("clr_accept_res", {28'd0, bus.result}, 32'b1101);
    drive(1'b1, 3'b000, 1'b1, 1'b0, 4'h0, 4'b1111);
    @(negedge clk);
    check_eq("clr_accept_acc", {28'd0, bus.result}, 32'b1101);

    // Backpressure: second beat stalls until out_ready returns
    drive(1'b0, 3'd0, 1'b0, 1'b0, 4'h0, 4'h0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b000, 1'b0, 1'b0, 4'hF, 4'h3);
    @(negedge clk);
    check_eq("bp_first", {28'd0, bus.result}, 32'h3);
    check_eq("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    drive(1'b1, 3'b001, 1'b0, 1'b0, 4'h8, 4'h4);
    repeat (2) @(negedge clk);
    check_eq("bp_hold", {28'd0, bus.result}, 32'h3);
    check_eq("bp_hold_vld", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    #1;
    check_eq("bp_ready_comb", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    check_eq("bp_second", {28'd0, bus.result}, 32'hC);
    check_eq("bp_second_vld", {31'd0, bus.out_valid}, 32'd1);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 4'h0, 4'h0);
    @(negedge clk);
    check_eq("bp_no_dup", {31'd0, bus.out_valid}, 32'd0);

`ifdef BITWISE_LOGIC_FLAGS_EN
    drive(1'b1, 3'b010, 1'b0, 1'b0, 4'hF, 4'hE);
    @(negedge clk);
    check_eq("flg_xor_res", {28'd0, bus.result}, 32'h1);
    check_eq("flg_parity", {31'd0, bus.parity}, 32'd1);
    check_eq("flg_ones0", {31'd0, bus.ones}, 32'd0);
    check_eq("flg_zero0", {31'd0, bus.zero}, 32'd0);
    drive(1'b1, 3'b101, 1'b0, 1'b0, 4'h9, 4'h9);
    @(negedge clk);
    check_eq("flg_ones1", {31'd0, bus.ones}, 32'd1);
    check_eq("flg_parity0", {31'd0, bus.parity}, 32'd0);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 4'h0, 4'h0);
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_unit.md
Name: bitwise_logic_unit

Overview:
Parametrised, registered successor to the team's single-function combinational AND: an 8-operation bitwise logic unit with a valid/ready stream interface on both sides.
- Adds an internal accumulator so chained bitwise reductions (mask building, flag merging) run without an external register.
- Sits between the operand-fetch stage and the result bus of the datapath.

Parameters:
WIDTH, 4, operand/result/accumulator width in bits (>=1)
ACC_RST, 0, reset and clear value of the accumulator (WIDTH bits, zero-extended)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat present
in_ready  output  1  unit can accept a beat this cycle
op  input  3  operation select, sampled with the beat
acc_sel  input  1  1: operand A is the accumulator, port a ignored
acc_clr  input  1  synchronous accumulator clear, independent of handshake
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result register holds a beat
out_ready  input  1  downstream accepts the beat
result  output  WIDTH  registered result
zero  output  1  registered: result == 0

Behaviour:
- Interface decided: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, asynchronous): out_valid=0, result=0, zero=1, acc=ACC_RST. in_ready=1 once rst_n high.
- Op encoding, with A = acc_sel ? acc : a:
  - 000 AND A&b
  - 001 OR A|b
  - 010 XOR A^b
  - 011 NAND ~(A&b)
  - 100 NOR ~(A|b)
  - 101 XNOR ~(A^b)
  - 110 ANDN A&~b
  - 111 NOT ~A (b ignored)
- All ops are pure WIDTH-bit; no carries, no extension.
- Accept: in_valid && in_ready. in_ready = !out_valid || out_ready (combinational, no bubble under full throughput).
- Latency: 1 cycle. A beat accepted at edge N appears with out_valid=1 after edge N.
- Output register loads only on accept; result and zero stay stable while out_valid && !out_ready.
- out_valid:
  - set on accept
  - cleared on out_ready when no accept occurs in the same cycle
  - stays 1 on simultaneous drain+accept (back-to-back beats)
- Accumulator:
  - on every accept, acc <= computed result, whether or not acc_sel=1
  - acc_clr=1 with no accept: acc <= ACC_RST
  - acc_clr=1 with an accept in the same cycle: the accept wins, acc <= result. The computation itself uses the pre-clear acc value.
- Backpressure: in_valid held while in_ready=0 changes nothing. Operands are not required to be stable.
- Reset mid-stream: any in-flight beat is discarded and the accumulator is restored to ACC_RST.

Optional Feature:
Macro BITWISE_LOGIC_FLAGS_EN.
- Defined: two extra outputs, both registered with result and reset to their reset-result values:
  - parity (1 bit, XOR-reduce of result; reset 0)
  - ones (1 bit, result all ones; reset 0)
- Not defined: these ports do not exist. Only zero is produced.

Test Plan:
- Reset, WIDTH=4: assert rst_n=0 mid-cycle -> out_valid=0, result=0, zero=1 immediately; in_ready=1 after release.
- Op sweep with a=4'b1100, b=4'b1010, out_ready=1 -> results in order:
  - AND 1000, OR 1110, XOR 0110, NAND 0111
  - NOR 0001, XNOR 1001, ANDN 0100, NOT 0011
  - each one cycle after its accept
- Accumulate, ACC_RST=4'hF, acc_sel=1: op=AND with b=1110, 1011, 0111 -> results 1110, 1010, 0010. Then acc_clr alone -> next AND with b=1111 gives 1111.
- Backpressure: out_ready=0 with two beats offered -> in_ready=0 after the first; result holds its first value. Release out_ready -> second result on the next cycle, no beat lost or duplicated.
- Simultaneous acc_clr and accept, acc=0101: op=OR, b=1000 -> result 1101, acc=1101 (accept wins).
- With BITWISE_LOGIC_FLAGS_EN: XOR a=1111, b=1110 -> result 0001, parity=1, ones=0, zero=0; XNOR with equal operands -> ones=1.
